// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with synchronous reads and a sweep-clear FSM.
// Optional write-first read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned NREAD    = 2,
   parameter int unsigned ADDR_W   = $clog2(DEPTH),
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NREAD*ADDR_W-1:0]  ra_i,
   output logic [NREAD*DATA_W-1:0]  rd_o,
   input  logic                     we_i,
   input  logic [ADDR_W-1:0]        wa_i,
   input  logic [DATA_W-1:0]        wd_i,
   input  logic                     clr_i,
   output logic                     busy_o
);

   typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_e;

   state_e                   r_state;
   state_e                   w_state_nxt;
   logic [ADDR_W-1:0]        r_idx;
   logic [ADDR_W-1:0]        w_idx_nxt;
   logic                     r_busy;
   logic [NREAD*DATA_W-1:0]  r_rd;
   logic [DATA_W-1:0]        r_regs [DEPTH];

   logic                     w_wr_legal;
   logic                     w_arr_we;
   logic [ADDR_W-1:0]        w_arr_wa;
   logic [DATA_W-1:0]        w_arr_wd;
   logic [NREAD*DATA_W-1:0]  w_rd_nxt;
   logic [ADDR_W-1:0]        w_ra [NREAD];

   for (genvar g = 0; g < NREAD; g++) begin : g_ra
      assign w_ra[g] = ra_i[g*ADDR_W +: ADDR_W];
   end

   assign w_wr_legal = we_i && (32'(wa_i) < DEPTH) && !(ZERO_REG && (wa_i == '0));

   // State register, sweep index and registered busy flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_CLEAR;
         r_idx   <= '0;
         r_busy  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_busy  <= (w_state_nxt == ST_CLEAR);
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      unique case (r_state)
         ST_CLEAR: begin
            w_idx_nxt = r_idx + ADDR_W'(1);
            if (r_idx == ADDR_W'(DEPTH - 1)) begin
               w_state_nxt = ST_IDLE;
               w_idx_nxt   = '0;
            end
         end
         ST_IDLE: begin
            if (clr_i) begin
               w_state_nxt = ST_CLEAR;
               w_idx_nxt   = '0;
            end
         end
         default: w_state_nxt = ST_CLEAR;
      endcase
   end

   // Array write port and next read data; a clear request drops a same-cycle write
   always_comb begin
      w_arr_we = 1'b0;
      w_arr_wa = wa_i;
      w_arr_wd = wd_i;
      w_rd_nxt = '0;
      if (r_state == ST_CLEAR) begin
         w_arr_we = 1'b1;
         w_arr_wa = r_idx;
         w_arr_wd = '0;
      end else begin
         w_arr_we = w_wr_legal && !clr_i;
         for (int unsigned k = 0; k < NREAD; k++) begin
            if ((32'(w_ra[k]) < DEPTH) && !(ZERO_REG && (w_ra[k] == '0))) begin
               w_rd_nxt[k*DATA_W +: DATA_W] = r_regs[w_ra[k]];
`ifdef REGFILE_BYPASS_EN
               if (w_arr_we && (w_ra[k] == wa_i)) begin
                  w_rd_nxt[k*DATA_W +: DATA_W] = wd_i;
               end
`endif
            end
         end
      end
   end

   // Storage has no reset; the sweep zeroes it
   always_ff @(posedge clk_i) begin
      if (w_arr_we) begin
         r_regs[w_arr_wa] <= w_arr_wd;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rd <= '0;
      end else begin
         r_rd <= w_rd_nxt;
      end
   end

   assign rd_o   = r_rd;
   assign busy_o = r_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised self-checking bench for regfile_mp: default 32x32/2-port instance and a 24-deep 3-port instance.
module tb_regfile_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Active instance selector and generic stimulus
   int          sel   = 0;
   int          depth = 32;
   int          nread = 2;
   logic        in_we  = 1'b0;
   int          in_wa  = 0;
   logic [31:0] in_wd  = '0;
   logic        in_clr = 1'b0;
   int          in_ra [3] = '{0, 0, 0};

   logic        a_rst_n = 1'b0;
   logic [9:0]  a_ra;
   logic [63:0] a_rd;
   logic        a_we, a_clr, a_busy;
   logic [4:0]  a_wa;
   logic [31:0] a_wd;

   logic        b_rst_n = 1'b0;
   logic [14:0] b_ra;
   logic [95:0] b_rd;
   logic        b_we, b_clr, b_busy;
   logic [4:0]  b_wa;
   logic [31:0] b_wd;

   assign a_we  = (sel == 0) && in_we;
   assign a_clr = (sel == 0) && in_clr;
   assign a_wa  = 5'(in_wa);
   assign a_wd  = in_wd;
   assign a_ra  = {5'(in_ra[1]), 5'(in_ra[0])};
   assign b_we  = (sel == 1) && in_we;
   assign b_clr = (sel == 1) && in_clr;
   assign b_wa  = 5'(in_wa);
   assign b_wd  = in_wd;
   assign b_ra  = {5'(in_ra[2]), 5'(in_ra[1]), 5'(in_ra[0])};

   regfile_mp u_dut_a (
      .clk_i(clk), .rst_ni(a_rst_n), .ra_i(a_ra), .rd_o(a_rd),
      .we_i(a_we), .wa_i(a_wa), .wd_i(a_wd), .clr_i(a_clr), .busy_o(a_busy)
   );

   regfile_mp #(.DEPTH(24), .NREAD(3)) u_dut_b (
      .clk_i(clk), .rst_ni(b_rst_n), .ra_i(b_ra), .rd_o(b_rd),
      .we_i(b_we), .wa_i(b_wa), .wd_i(b_wd), .clr_i(b_clr), .busy_o(b_busy)
   );

   // Reference model: register contents and remaining clear cycles
   logic [31:0] m_regs [32];
   int          m_sweep;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] obs_rd(input int k);
      if (sel == 1) return b_rd[k*32 +: 32];
      return 32'(a_rd[k*32 +: 32]);
   endfunction

   function automatic logic [31:0] obs_busy();
      return (sel == 1) ? 32'(b_busy) : 32'(a_busy);
   endfunction

   task automatic set_rst(input logic v);
      if (sel == 1) b_rst_n = v;
      else          a_rst_n = v;
   endtask

   task automatic drive(input logic we, input int wa, input logic [31:0] wd, input logic clr,
                        input int r0, input int r1, input int r2);
      in_we = we; in_wa = wa; in_wd = wd; in_clr = clr;
      in_ra[0] = r0; in_ra[1] = r1; in_ra[2] = r2;
   endtask

   task automatic drive_idle_read(input int r0, input int r1, input int r2);
      drive(1'b0, 0, '0, 1'b0, r0, r1, r2);
   endtask

   // One clock: predict from the model, clock the DUT, compare
   task automatic step();
      logic [31:0] exp_rd [3];
      logic        legal;
      legal = in_we && (in_wa < depth) && (in_wa != 0);
      for (int k = 0; k < 3; k++) exp_rd[k] = '0;
      if (m_sweep > 0) begin
         m_sweep--;
      end else begin
         for (int k = 0; k < nread; k++) begin
            if (in_ra[k] < depth && in_ra[k] != 0) exp_rd[k] = m_regs[in_ra[k]];
`ifdef REGFILE_BYPASS_EN
            if (legal && !in_clr && in_ra[k] == in_wa) exp_rd[k] = in_wd;
`endif
         end
         if (in_clr) begin
            m_sweep = depth;
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
         end else if (legal) begin
            m_regs[in_wa] = in_wd;
         end
      end
      @(posedge clk); #1;
      check("busy", obs_busy(), 32'(m_sweep > 0));
      for (int k = 0; k < nread; k++) check($sformatf("rd%0d", k), obs_rd(k), exp_rd[k]);
   endtask

   task automatic do_reset(input int n);
      set_rst(1'b0);
      drive_idle_read(1, 2, 3);
      repeat (n) begin
         @(posedge clk); #1;
         check("rst_busy", obs_busy(), 32'd1);
         for (int k = 0; k < nread; k++) check("rst_rd", obs_rd(k), '0);
      end
      set_rst(1'b1);
      m_sweep = depth;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
   endtask

   task automatic read_all();
      for (int i = 0; i < 32; i += nread) drive_idle_read(i, (i + 1) % 32, (i + 2) % 32);
      for (int i = 0; i < 32; i += nread) begin
         drive_idle_read(i, (i + 1) % 32, (i + 2) % 32);
         step();
      end
   endtask

   task automatic random_run(input int n);
      repeat (n) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom, $urandom_range(0, 63) == 0,
               $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
         step();
      end
   endtask

   int busy_cycles;

   initial begin
      // Default instance: 32 deep, 2 read ports
      @(posedge clk); #1;
      do_reset(3);
      busy_cycles = 0;
      repeat (34) begin
         drive_idle_read($urandom_range(0, 31), $urandom_range(0, 31), 0);
         step();
         if (obs_busy() != 0) busy_cycles++;
      end
      check("reset_busy_len", 32'(busy_cycles), 32'd31);
      read_all();

      drive(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 0, 0); step();
      drive_idle_read(5, 5, 0); step();
      check("dead_p0", obs_rd(0), 32'hDEADBEEF);
      check("dead_p1", obs_rd(1), 32'hDEADBEEF);

      drive(1'b1, 0, 32'h12345678, 1'b0, 0, 0, 0); step();
      drive_idle_read(0, 5, 0); step();
      check("zero_reg", obs_rd(0), 32'h0);

      drive(1'b1, 7, 32'h1, 1'b0, 0, 0, 0); step();
      drive(1'b1, 7, 32'hA5A5A5A5, 1'b0, 7, 3, 0); step();
`ifdef REGFILE_BYPASS_EN
      check("collide", obs_rd(0), 32'hA5A5A5A5);
`else
      check("collide", obs_rd(0), 32'h1);
`endif
      drive_idle_read(7, 7, 0); step();
      check("collide_after", obs_rd(1), 32'hA5A5A5A5);

      for (int i = 1; i < 32; i++) begin
         drive(1'b1, i, $urandom | 32'h1, 1'b0, i, 0, 0);
         step();
      end
      drive(1'b1, 3, 32'h55, 1'b1, 3, 4, 0); step();
      busy_cycles = 0;
      repeat (33) begin
         drive(1'b1, $urandom_range(1, 31), $urandom, 1'b1, $urandom_range(1, 31), 3, 0);
         step();
         if (obs_busy() != 0) busy_cycles++;
      end
      check("clr_busy_len", 32'(busy_cycles), 32'd32);
      read_all();
      random_run(400);

      // Second instance: 24 deep, 3 read ports
      drive_idle_read(0, 0, 0);
      sel = 1; depth = 24; nread = 3;
      do_reset(2);
      repeat (10) begin drive_idle_read($urandom_range(0, 31), 5, 27); step(); end
      do_reset(2);
      busy_cycles = 0;
      repeat (26) begin
         drive_idle_read($urandom_range(0, 31), 23, 27);
         step();
         if (obs_busy() != 0) busy_cycles++;
      end
      check("mid_rst_busy_len", 32'(busy_cycles), 32'd23);
      read_all();
      drive(1'b1, 27, 32'hCAFEF00D, 1'b0, 27, 27, 27); step();
      drive(1'b1, 23, 32'h0BADF00D, 1'b0, 27, 23, 3); step();
      drive_idle_read(27, 23, 3); step();
      check("oor_read", obs_rd(0), 32'h0);
      check("last_reg", obs_rd(1), 32'h0BADF00D);
      random_run(400);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file: the successor to the core's fixed 32x32, two-read-port register file. It provides configurable width, depth and read-port count, synchronous reads, and hardwired-zero handling for register 0. A sweep-clear state machine zeroes the array after reset or on request, so no simulation-only initialisation is needed. It sits in the decode stage of the core and is shared by the integer pipeline and the debug unit.

## Interface
- `DATA_W`, default 32, register width in bits
- `DEPTH`, default 32, number of registers (2..256, need not be a power of two)
- `NREAD`, default 2, number of read ports (1..4)
- `ADDR_W`, default `$clog2(DEPTH)`, address width; derived, do not override
- `ZERO_REG`, default 1, if 1 register 0 reads as zero and ignores writes

- `clk_i`, input, 1, clock; all state updates on the rising edge
- `rst_ni`, input, 1, asynchronous active-low reset
- `ra_i`, input, `NREAD*ADDR_W`, read addresses; port k is at bits `[k*ADDR_W +: ADDR_W]`
- `rd_o`, output, `NREAD*DATA_W`, registered read data; port k is at bits `[k*DATA_W +: DATA_W]`
- `we_i`, input, 1, write enable
- `wa_i`, input, `ADDR_W`, write address
- `wd_i`, input, `DATA_W`, write data
- `clr_i`, input, 1, single-cycle request to zero the whole array
- `busy_o`, output, 1, high while a clear sweep is in progress

## Operation
- **State machine:** two states, IDLE and CLEAR, plus a sweep index `idx` of `ADDR_W` bits.
- **Reset (`rst_ni` low):**
  - state = CLEAR, `idx` = 0
  - `busy_o` = 1
  - every `rd_o` lane = 0
  - array contents are not reset directly
- **CLEAR state:**
  - Each cycle writes 0 to `regs[idx]` and increments `idx`.
  - When `idx == DEPTH-1`, that entry is written and the state moves to IDLE.
  - `we_i` and `clr_i` are ignored.
  - Every `rd_o` lane is forced to 0.
- **IDLE state, `clr_i` = 1:** the state moves to CLEAR with `idx` = 0. Any write in the same cycle is dropped, so the clear wins.
- **IDLE state, write:** if `we_i` = 1, `wa_i < DEPTH`, and not (`ZERO_REG` and `wa_i == 0`), then `regs[wa_i] <= wd_i`.
- **Read, each port k:** `rd_o[k] <= regs[ra_i[k]]` every cycle.
  - The lane returns 0 if `ra_i[k] >= DEPTH`.
  - The lane returns 0 if `ZERO_REG` and `ra_i[k] == 0`.
  - Same-cycle write/read collisions follow the Configuration section.
- **Out-of-range write** (`wa_i >= DEPTH`): dropped silently.
- **Reset mid-sweep:** the sweep restarts from `idx` 0 after `rst_ni` rises, and the full `DEPTH` cycles are taken again.

## Timing
- Read latency is 1 cycle: an address presented at edge N gives data valid after edge N+1.
- A write presented at edge N is visible to a read presented at edge N+1, with data out after edge N+2.
- A clear sweep takes exactly `DEPTH` cycles from the first CLEAR edge.
  - `busy_o` falls after the edge that writes entry `DEPTH-1`.
  - The first write or read accepted is in the following cycle.
- `busy_o` is registered, with no combinational path from `clr_i`. It rises the cycle after `clr_i` is sampled in IDLE.
- There is no combinational path from any input to any output.

## Configuration
- **`REGFILE_BYPASS_EN` defined:** write-first behaviour.
  - If in IDLE, `we_i` = 1, the write is legal, and `ra_i[k] == wa_i`, then `rd_o[k]` gets `wd_i` in the same cycle.
  - Each port compares independently.
  - Bypass never applies to register 0 when `ZERO_REG` = 1.
  - Bypass never applies to an out-of-range address.
- **`REGFILE_BYPASS_EN` undefined:** read-first behaviour. A colliding read returns the old array contents; this matches the previous generation.

## Test plan
- **Reset sweep:** hold `rst_ni` low 3 cycles, release. Required: `busy_o` = 1 for exactly 32 cycles (defaults), then 0; reads of all 32 registers return 0.
- **Basic write/read:** write 0xDEADBEEF to r5, then read r5 on port 0 and r5 on port 1. Required: both lanes show 0xDEADBEEF one cycle after the address.
- **Zero register:** write 0x12345678 to r0, then read r0. Required: 0.
- **Collision:** in the same cycle write 0xA5A5A5A5 to r7 (old value 0x1) and read r7. Required: 0xA5A5A5A5 with `REGFILE_BYPASS_EN`, 0x1 without it.
- **Clear request:** fill r1..r31 with nonzero values, pulse `clr_i` together with a write of 0x55 to r3. Required: the write is dropped, `busy_o` is high for 32 cycles, `rd_o` = 0 throughout, and all registers read 0 afterwards.
- **Reset mid-sweep and odd depth:** with `DEPTH`=24 and `NREAD`=3, assert `rst_ni` low at sweep cycle 10, then release. Required: `busy_o` high for 24 more cycles; a write to address 27 is dropped; a read of address 27 returns 0.
